// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle control FSM and its ALU decoder.
package multicycle_control_pkg;

    // FSM state encodings; values are visible on the debug state port.
    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        WB     = 3'd3,
        HALT   = 3'd4
    } state_t;

    // Supported opcodes.
    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;

    // Supported funct3 values.
    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_SLT = 3'b010;

    // ALU operation codes.
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/multicycle_control_alu_decoder.sv
// Combinational decode of opcode/funct3/funct7[5] into ALU controls and an illegal flag.
module alu_decoder
    import multicycle_control_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_b5,
    output logic [2:0] alu_control,
    output logic       alu_src,
    output logic       illegal
);

    logic is_r;
    logic is_i;

    assign is_r = (opcode == OP_R);
    assign is_i = (opcode == OP_I);

    // Map the instruction fields to ALU operation, operand select and legality.
    always_comb begin
        alu_control = ALU_ADD;
        alu_src     = 1'b0;
        illegal     = 1'b1;
        if (is_r || is_i) begin
            alu_src = is_i;
            illegal = 1'b0;
            case (funct3)
                F3_ADD:  alu_control = (is_r && funct7_b5) ? ALU_SUB : ALU_ADD;
                F3_AND:  alu_control = ALU_AND;
                F3_OR:   alu_control = ALU_OR;
                F3_SLT:  alu_control = ALU_SLT;
                default: illegal     = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle FETCH/DECODE/EXEC/WB control FSM with sticky HALT and retired-instruction counter.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [31:0]      instr,
    output logic             mem_read,
    output logic             ir_load,
    output logic             alu_src,
    output logic [2:0]       alu_control,
    output logic             reg_write,
    output logic             pc_enable,
    output logic             halted,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired
);

    state_t     state_q;
    state_t     state_d;
    logic [2:0] dec_alu_control;
    logic       dec_alu_src;
    logic       dec_illegal;
    logic       unused_instr_bits;

    assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

    alu_decoder u_alu_decoder (
        .opcode      (instr[6:0]),
        .funct3      (instr[14:12]),
        .funct7_b5   (instr[30]),
        .alu_control (dec_alu_control),
        .alu_src     (dec_alu_src),
        .illegal     (dec_illegal)
    );

    // State register; reset wins so an in-flight instruction is abandoned.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and strobe decode from the registered state (run gates the fetch only).
    always_comb begin
        state_d   = state_q;
        mem_read  = 1'b0;
        ir_load   = 1'b0;
        reg_write = 1'b0;
        pc_enable = 1'b0;
        halted    = 1'b0;
        case (state_q)
            FETCH: begin
                if (run) begin
                    mem_read = 1'b1;
                    ir_load  = 1'b1;
                    state_d  = DECODE;
                end
            end
            DECODE:  state_d = dec_illegal ? HALT : EXEC;
            EXEC:    state_d = WB;
            WB: begin
                reg_write = 1'b1;
                pc_enable = 1'b1;
                state_d   = FETCH;
            end
            HALT:    halted  = 1'b1;
            default: state_d = FETCH;
        endcase
    end

    // Capture decoded ALU controls on leaving DECODE; they hold through EXEC and WB.
    always_ff @(posedge clk) begin
        if (reset) begin
            alu_src     <= 1'b0;
            alu_control <= '0;
        end else if (state_q == DECODE && !dec_illegal) begin
            alu_src     <= dec_alu_src;
            alu_control <= dec_alu_control;
        end
    end

    // Count completed instructions; wraps silently.
    always_ff @(posedge clk) begin
        if (reset) begin
            retired <= '0;
        end else if (state_q == WB) begin
            retired <= retired + CNT_W'(1);
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: stimulus pushes expected WB results, a monitor checks them.
module tb_multicycle_control;

    localparam int unsigned CW = 4;

    logic          clk;
    logic          reset;
    logic          run;
    logic [31:0]   instr;
    logic          mem_read;
    logic          ir_load;
    logic          alu_src;
    logic [2:0]    alu_control;
    logic          reg_write;
    logic          pc_enable;
    logic          halted;
    logic [2:0]    state;
    logic [CW-1:0] retired;

    int n_cmp;
    int n_bad;

    typedef struct {
        logic          src;
        logic [2:0]    ctl;
        logic [CW-1:0] ret_after;
    } exp_t;

    exp_t          sb[$];
    logic [CW-1:0] exp_ret;
    logic          ret_pending;
    logic [CW-1:0] pend_ret;

    multicycle_control #(.CNT_W(CW)) dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .instr       (instr),
        .mem_read    (mem_read),
        .ir_load     (ir_load),
        .alu_src     (alu_src),
        .alu_control (alu_control),
        .reg_write   (reg_write),
        .pc_enable   (pc_enable),
        .halted      (halted),
        .state       (state),
        .retired     (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] f3, input logic f7);
        logic [31:0] w;
        w        = '0;
        w[6:0]   = op;
        w[11:7]  = 5'd3;
        w[14:12] = f3;
        w[19:15] = 5'd1;
        w[24:20] = 5'd2;
        w[30]    = f7;
        return w;
    endfunction

    // Monitor: every WB strobe must match the oldest expected entry.
    always @(negedge clk) begin
        exp_t e;
        if (ret_pending) begin
            check("retired_after_wb", 32'(retired), 32'(pend_ret));
            ret_pending = 1'b0;
        end
        if (reg_write || pc_enable) begin
            if (sb.size() == 0) begin
                check("spurious_wb_strobe", {30'd0, reg_write, pc_enable}, 32'd0);
            end else begin
                e = sb.pop_front();
                check("wb_strobes", {30'd0, reg_write, pc_enable}, 32'd3);
                check("wb_state", 32'(state), 32'd3);
                check("wb_alu_src", 32'(alu_src), 32'(e.src));
                check("wb_alu_control", 32'(alu_control), 32'(e.ctl));
                pend_ret    = e.ret_after;
                ret_pending = 1'b1;
            end
        end
    end

    // One legal instruction: FETCH, DECODE, EXEC, WB, ending at the next FETCH negedge.
    task automatic do_instr(input logic [31:0] w, input logic src, input logic [2:0] ctl);
        exp_t e;
        check("fetch_state", 32'(state), 32'd0);
        run   = 1'b1;
        instr = w;
        #1;
        check("fetch_strobes", {30'd0, mem_read, ir_load}, 32'd3);
        exp_ret     = exp_ret + 1'b1;
        e.src       = src;
        e.ctl       = ctl;
        e.ret_after = exp_ret;
        sb.push_back(e);
        @(negedge clk);
        check("decode_strobes", {29'd0, mem_read, ir_load, reg_write}, 32'd0);
        run = 1'b0;
        @(negedge clk);
        check("exec_state", 32'(state), 32'd2);
        run   = 1'b1;
        instr = 32'hFFFF_FFFF;
        @(negedge clk);
        run = 1'b0;
        @(negedge clk);
    endtask

    // Illegal instruction: must reach sticky HALT, then reset recovers.
    task automatic do_illegal(input logic [31:0] w);
        check("ill_fetch_state", 32'(state), 32'd0);
        run   = 1'b1;
        instr = w;
        @(negedge clk);
        run = 1'b0;
        @(negedge clk);
        check("halt_state", 32'(state), 32'd4);
        check("halt_flag", 32'(halted), 32'd1);
        for (int i = 0; i < 4; i++) begin
            run   = i[0];
            instr = mk(7'b0110011, 3'b000, 1'b0);
            @(negedge clk);
            check("halt_sticky", {27'd0, state, mem_read, reg_write}, {27'd0, 3'd4, 2'b00});
        end
        reset = 1'b1;
        @(negedge clk);
        check("halt_reset_state", 32'(state), 32'd0);
        check("halt_reset_flag", 32'(halted), 32'd0);
        check("halt_reset_retired", 32'(retired), 32'd0);
        reset   = 1'b0;
        exp_ret = '0;
    endtask

    initial begin
        n_cmp       = 0;
        n_bad       = 0;
        exp_ret     = '0;
        ret_pending = 1'b0;
        reset       = 1'b1;
        run         = 1'b0;
        instr       = '0;
        @(negedge clk);
        @(negedge clk);
        check("reset_state", 32'(state), 32'd0);
        check("reset_strobes", {28'd0, mem_read, ir_load, reg_write, pc_enable}, 32'd0);
        check("reset_alu", {28'd0, alu_src, alu_control}, 32'd0);
        check("reset_retired", 32'(retired), 32'd0);
        check("reset_halted", 32'(halted), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // add, sub, ori, plus the remaining legal decodes
        do_instr(32'h002081B3, 1'b0, 3'b010);
        do_instr(32'h40208233, 1'b0, 3'b110);
        do_instr(32'h00A0E093, 1'b1, 3'b001);
        do_instr(mk(7'b0110011, 3'b111, 1'b0), 1'b0, 3'b000);
        do_instr(mk(7'b0110011, 3'b010, 1'b0), 1'b0, 3'b111);
        do_instr(mk(7'b0010011, 3'b111, 1'b0), 1'b1, 3'b000);
        do_instr(mk(7'b0010011, 3'b000, 1'b1), 1'b1, 3'b010);
        do_instr(mk(7'b0010011, 3'b010, 1'b0), 1'b1, 3'b111);

        // run held low in FETCH
        for (int i = 0; i < 10; i++) begin
            instr = 32'h002081B3;
            #1;
            check("idle_outputs", {27'd0, state, mem_read, ir_load}, 32'd0);
            check("idle_wb", {30'd0, reg_write, pc_enable}, 32'd0);
            @(negedge clk);
        end
        do_instr(32'h40208233, 1'b0, 3'b110);

        // reset while in EXEC aborts the instruction
        run   = 1'b1;
        instr = 32'h002081B3;
        @(negedge clk);
        run = 1'b0;
        @(negedge clk);
        check("abort_exec_state", 32'(state), 32'd2);
        reset = 1'b1;
        @(negedge clk);
        check("abort_state", 32'(state), 32'd0);
        check("abort_wb", {30'd0, reg_write, pc_enable}, 32'd0);
        check("abort_retired", 32'(retired), 32'd0);
        reset   = 1'b0;
        exp_ret = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_quiet", {29'd0, state == 3'd0, reg_write, pc_enable}, 32'd4);
        end

        // 16 back-to-back adds wrap the 4-bit counter to 0
        for (int i = 0; i < 16; i++) begin
            do_instr(32'h002081B3, 1'b0, 3'b010);
        end
        check("wrap_retired", 32'(retired), 32'd0);

        // illegal instructions
        do_illegal(32'h0000_0000);
        do_illegal(mk(7'b1100011, 3'b000, 1'b0));
        do_illegal(mk(7'b0110011, 3'b001, 1'b0));
        do_illegal(mk(7'b0010011, 3'b101, 1'b0));

        // legal operation still works after a halt/reset
        do_instr(32'h00A0E093, 1'b1, 3'b001);

        for (int i = 0; i < 10 && sb.size() != 0; i++) begin
            @(negedge clk);
        end
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; the clock port is clk and the reset port is reset.
REQ-002 Parameter CNT_W, default 16, SHALL set the width of the retired-instruction counter.
REQ-003 Port clk, input, 1, rising-edge clock for all state.
REQ-004 Port reset, input, 1, synchronous active-high reset.
REQ-005 Port run, input, 1, permits a new fetch when high.
REQ-006 Port instr, input, 32, instruction word from instruction memory; fields are opcode [6:0], funct3 [14:12] and funct7 bit 5 [30].
REQ-007 Port mem_read, output, 1, instruction-memory read strobe.
REQ-008 Port ir_load, output, 1, instruction-register load strobe.
REQ-009 Port alu_src, output, 1, ALU B-operand select: 0 = register Data2, 1 = sign-extended immediate.
REQ-010 Port alu_control, output, 3, ALU operation code.
REQ-011 Port reg_write, output, 1, register-bank write strobe.
REQ-012 Port pc_enable, output, 1, PC advance strobe.
REQ-013 Port halted, output, 1, high while the block is in the HALT state.
REQ-014 Port state, output, 3, current state encoding, for debug display.
REQ-015 Port retired, output, CNT_W, count of completed instructions.

Function
REQ-016 The FSM SHALL have states FETCH=0, DECODE=1, EXEC=2, WB=3 and HALT=4.
REQ-017 FETCH with run=0: all strobes low; the FSM stays in FETCH.
REQ-018 FETCH with run=1: mem_read=1 and ir_load=1 for exactly one cycle; next state is DECODE.
REQ-019 DECODE SHALL sample instr and register alu_src and alu_control, which then hold stable through EXEC and WB; next state is EXEC, or HALT if the instruction is illegal.
REQ-020 Legal instructions are: opcode 0110011 (R-type, alu_src=0) and opcode 0010011 (I-type, alu_src=1), each with funct3 in {000, 111, 110, 010}.
REQ-021 alu_control mapping: funct3 000 gives 010 (ADD), or 110 (SUB) when R-type and funct7[5]=1; 111 gives 000 (AND); 110 gives 001 (OR); 010 gives 111 (SLT).
REQ-022 Any other opcode, any other funct3, or instr=0x00000000 SHALL be illegal and transition to HALT; reg_write and pc_enable are never asserted for it.
REQ-023 EXEC: all strobes low, the ALU settles; next state is WB.
REQ-024 WB: reg_write=1 and pc_enable=1 for exactly one cycle; retired increments by 1; next state is FETCH.
REQ-025 Each legal instruction SHALL take exactly 4 cycles from the FETCH cycle with run=1 to the WB cycle, inclusive.
REQ-026 retired SHALL wrap from 2^CNT_W-1 to 0 without a flag.
REQ-027 HALT is sticky: all strobes low and halted=1; only reset exits HALT.
REQ-028 A change of run outside FETCH SHALL not affect the instruction in flight.
REQ-029 All outputs SHALL be registered or decoded from registered state only, with no combinational path from instr to any output.

Reset
REQ-030 Reset SHALL force state=FETCH, all strobes to 0, alu_src=0, alu_control=000, retired=0 and halted=0 on the next clk edge.
REQ-031 Reset asserted in DECODE, EXEC or WB SHALL abort the instruction: no reg_write, no pc_enable and no retired increment on that edge.

Structure
REQ-032 A shared package SHALL hold the state encodings, opcode constants (OP_R, OP_I) and ALU control codes (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT).
REQ-033 A combinational sub-module alu_decoder SHALL map opcode, funct3 and funct7[5] to alu_control, alu_src and an illegal flag; the FSM registers its outputs in DECODE.

Verification
REQ-034 Reset then run=1 with instr=0x002081B3 (add x3,x1,x2): ir_load in cycle 1; reg_write=1, pc_enable=1, alu_src=0 and alu_control=010 in cycle 4; retired=1.
REQ-035 instr=0x40208233 (sub): alu_control=110; instr=0x00A0E093 (ori x1,x1,10): alu_src=1 and alu_control=001.
REQ-036 run=0 held for 10 cycles in FETCH: mem_read, ir_load and reg_write stay 0 and state stays 0; then run=1 restores the normal 4-cycle sequence.
REQ-037 instr=0x00000000 or opcode 1100011: state=4 and halted=1 after DECODE, with no reg_write; run toggling has no effect; reset returns state to 0.
REQ-038 Reset pulsed in EXEC: no WB strobes occur, retired stays 0 and state returns to 0.
REQ-039 With CNT_W=4, 16 back-to-back adds SHALL leave retired=0, with no spurious strobes.
